// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions.
// Holds the control-state encoding used by the bit-serial arithmetic blocks.
package arith_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: computes iA - iB - iBorrow.
// Ports:
//   iA      input  minuend bit
//   iB      input  subtrahend bit
//   iBorrow input  borrow-in from the previous (less significant) bit
//   oDiff   output difference bit
//   oBorrow output borrow-out toward the next (more significant) bit
module full_subtractor (
   input  logic iA,
   input  logic iB,
   input  logic iBorrow,
   output logic oDiff,
   output logic oBorrow
);

   assign oDiff   = iA ^ iB ^ iBorrow;
   // Borrow when b exceeds a, or when they are equal and a borrow is already pending.
   assign oBorrow = (~iA & iB) | (~(iA ^ iB) & iBorrow);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: A - B, LSB first, one bit per clock through a
// single full-subtractor cell with a registered borrow.
// Ports:
//   iClk    input     rising-edge clock
//   iRst    input     synchronous active-high reset
//   iStart  input     request, accepted only while oReady=1
//   iA, iB  input [N] operands, sampled on the accepting edge only
//   oReady  output    high in idle
//   oBusy   output    high while bits are being processed
//   oDone   output    one-cycle pulse, result valid
//   oDiff   output [N] (A - B) mod 2^N, held until the next completion
//   oBorrow output    final borrow, 1 iff A < B
module serial_subtractor
   import arith_pkg::*;
#(
   parameter int unsigned N = 8
) (
   input  logic         iClk,
   input  logic         iRst,
   input  logic         iStart,
   input  logic [N-1:0] iA,
   input  logic [N-1:0] iB,
   output logic         oReady,
   output logic         oBusy,
   output logic         oDone,
   output logic [N-1:0] oDiff,
   output logic         oBorrow
);

   localparam int unsigned   CW      = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LastCnt = CW'(N - 1);

   state_e         state_q;
   logic [N-1:0]   a_q;
   logic [N-1:0]   b_q;
   logic [N-1:0]   res_q;
   logic [N-1:0]   res_d;
   logic [N-1:0]   diff_q;
   logic           borrow_q;
   logic           bout_q;
   logic           done_q;
   logic [CW-1:0]  cnt_q;
   logic           cell_diff;
   logic           cell_borrow;

   full_subtractor u_cell (
      .iA      (a_q[0]),
      .iB      (b_q[0]),
      .iBorrow (borrow_q),
      .oDiff   (cell_diff),
      .oBorrow (cell_borrow)
   );

   // New bit enters at the MSB so that after N shifts bit 0 holds the first (LSB) result.
   if (N == 1) begin : g_res_one
      assign res_d = cell_diff;
   end else begin : g_res_multi
      assign res_d = {cell_diff, res_q[N-1:1]};
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q  <= StIdle;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         bout_q   <= 1'b0;
         done_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               done_q <= 1'b0;
               if (iStart) begin
                  a_q      <= iA;
                  b_q      <= iB;
                  borrow_q <= 1'b0;
                  cnt_q    <= '0;
                  state_q  <= StRun;
               end
            end
            StRun: begin
               a_q      <= a_q >> 1;
               b_q      <= b_q >> 1;
               res_q    <= res_d;
               borrow_q <= cell_borrow;
               cnt_q    <= cnt_q + CW'(1);
               if (cnt_q == LastCnt) begin
                  // Published results change only here, so they hold through later runs.
                  state_q <= StDone;
                  done_q  <= 1'b1;
                  diff_q  <= res_d;
                  bout_q  <= cell_borrow;
               end
            end
            StDone: begin
               done_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               done_q  <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign oReady  = (state_q == StIdle);
   assign oBusy   = (state_q == StRun);
   assign oDone   = done_q;
   assign oDiff   = diff_q;
   assign oBorrow = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

   localparam int unsigned N = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         ready;
   logic         busy;
   logic         done;
   logic [N-1:0] diff;
   logic         borrow;

   logic         start1;
   logic [0:0]   a1;
   logic [0:0]   b1;
   logic         ready1;
   logic         busy1;
   logic         done1;
   logic [0:0]   diff1;
   logic         borrow1;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.N(N)) u_dut (
      .iClk    (clk),
      .iRst    (rst),
      .iStart  (start),
      .iA      (a),
      .iB      (b),
      .oReady  (ready),
      .oBusy   (busy),
      .oDone   (done),
      .oDiff   (diff),
      .oBorrow (borrow)
   );

   serial_subtractor #(.N(1)) u_dut1 (
      .iClk    (clk),
      .iRst    (rst),
      .iStart  (start1),
      .iA      (a1),
      .iB      (b1),
      .oReady  (ready1),
      .oBusy   (busy1),
      .oDone   (done1),
      .oDiff   (diff1),
      .oBorrow (borrow1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs are driven and outputs sampled 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Full operation on the N=8 instance against plain integer arithmetic.
   task automatic op8(input string tag, input logic [N-1:0] av, input logic [N-1:0] bv);
      int          k       = 0;
      int          busy_n  = 0;
      int          ready_n = 0;
      logic [N-1:0] ed;
      logic         eb;
      ed = av - bv;
      eb = (av < bv);
      start = 1'b1;
      a     = av;
      b     = bv;
      step();
      start = 1'b0;
      a     = N'($urandom);
      b     = N'($urandom);
      while (!done && k < 4 * N) begin
         if (busy) busy_n++;
         if (ready) ready_n++;
         step();
         k++;
      end
      check({tag, " latency"}, k, N);
      check({tag, " busy cycles"}, busy_n, N);
      check({tag, " ready low in run"}, ready_n, 0);
      check({tag, " ready low in done"}, ready, 1'b0);
      check({tag, " diff"}, diff, ed);
      check({tag, " borrow"}, borrow, eb);
      step();
      check({tag, " done one cycle"}, done, 1'b0);
      check({tag, " ready after"}, ready, 1'b1);
      check({tag, " diff held"}, diff, ed);
   endtask

   task automatic count_done(input int cycles, output int n);
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         step();
         if (done) n++;
      end
   endtask

   initial begin
      int          k;
      int          nd;
      logic [N-1:0] ra;
      logic [N-1:0] rb;

      rst    = 1'b1;
      start  = 1'b0;
      a      = '0;
      b      = '0;
      start1 = 1'b0;
      a1     = '0;
      b1     = '0;
      step();
      step();
      rst = 1'b0;
      check("rst ready", ready, 1'b1);
      check("rst busy", busy, 1'b0);
      check("rst done", done, 1'b0);
      check("rst diff", diff, 0);
      check("rst borrow", borrow, 1'b0);
      check("rst1 ready", ready1, 1'b1);
      check("rst1 diff", diff1, 0);

      op8("200-55", 8'd200, 8'd55);
      op8("55-200", 8'd55, 8'd200);
      op8("0-1", 8'h00, 8'h01);
      op8("5a-5a", 8'h5A, 8'h5A);
      op8("ff-0", 8'hFF, 8'h00);

      // Second request mid-run must be ignored, operand changes must not matter.
      start = 1'b1;
      a     = 8'd10;
      b     = 8'd3;
      step();
      start = 1'b0;
      a     = 8'hC3;
      b     = 8'h3C;
      step();
      step();
      start = 1'b1;
      a     = 8'd1;
      b     = 8'd2;
      step();
      start = 1'b0;
      a     = 8'h77;
      k     = 0;
      while (!done && k < 4 * N) begin
         step();
         k++;
      end
      check("ignore done seen", done, 1'b1);
      check("ignore diff", diff, 8'd7);
      check("ignore borrow", borrow, 1'b0);
      count_done(2 * N, nd);
      check("ignore no second done", nd, 0);

      // Reset on the 4th run edge aborts the operation.
      start = 1'b1;
      a     = 8'd100;
      b     = 8'd1;
      step();
      start = 1'b0;
      step();
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("abort ready", ready, 1'b1);
      check("abort busy", busy, 1'b0);
      check("abort done", done, 1'b0);
      check("abort diff", diff, 0);
      check("abort borrow", borrow, 1'b0);
      count_done(2 * N, nd);
      check("abort no done", nd, 0);
      op8("9-4", 8'd9, 8'd4);

      // Held start: back-to-back operations, N+2 edges between done pulses.
      start = 1'b1;
      a     = 8'h33;
      b     = 8'h44;
      k     = 0;
      while (!done && k < 4 * N) begin
         step();
         k++;
      end
      check("held first done", done, 1'b1);
      step();
      k = 1;
      while (!done && k < 4 * N) begin
         step();
         k++;
      end
      start = 1'b0;
      check("held period", k, N + 2);
      check("held diff", diff, 8'hEF);
      check("held borrow", borrow, 1'b1);
      step();
      step();
      check("held idle", ready, 1'b1);

      for (int i = 0; i < 24; i++) begin
         ra = N'($urandom);
         rb = N'($urandom);
         op8($sformatf("rand%0d", i), ra, rb);
      end

      // N=1 instance: single run edge then done.
      start1 = 1'b1;
      a1     = 1'b0;
      b1     = 1'b1;
      step();
      start1 = 1'b0;
      check("n1 busy", busy1, 1'b1);
      step();
      check("n1 done", done1, 1'b1);
      check("n1 diff", diff1, 1'b1);
      check("n1 borrow", borrow1, 1'b1);
      step();
      check("n1 done pulse", done1, 1'b0);

      start1 = 1'b1;
      a1     = 1'b1;
      b1     = 1'b0;
      k      = 0;
      while (!done1 && k < 10) begin
         step();
         k++;
      end
      check("n1 held first", done1, 1'b1);
      step();
      k = 1;
      while (!done1 && k < 10) begin
         step();
         k++;
      end
      start1 = 1'b0;
      check("n1 held period", k, 3);
      check("n1 held diff", diff1, 1'b1);
      check("n1 held borrow", borrow1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial unsigned subtractor. Computes A − B LSB-first, one bit per clock, through a single full-subtractor cell and a registered borrow. It is the subtraction counterpart to the team's ripple full-adder datapath. It serves area-constrained arithmetic paths (compare/decrement units) that accept N-cycle latency. Start/done handshake with a busy indication.

Parameters:
N, 8, operand and result width in bits (N ≥ 1)
CW, $clog2(N) (min 1), bit-counter width (localparam, not overridable)

Ports:
iClk  input  1  rising-edge clock
iRst  input  1  synchronous active-high reset
iStart  input  1  request; accepted only when oReady=1
iA  input  N  minuend, sampled on the accepting edge only
iB  input  N  subtrahend, sampled on the accepting edge only
oReady  output  1  high iff state=IDLE
oBusy  output  1  high iff state=RUN
oDone  output  1  one-cycle pulse; result valid
oDiff  output  N  (A − B) mod 2^N
oBorrow  output  1  final borrow-out; 1 iff A < B (unsigned)

Behaviour:
- Clock and reset: one clock, iClk. Reset is synchronous and active-high on iRst. Every register updates only on the rising edge of iClk.
- Reset values: state=IDLE, oReady=1, oBusy=0, oDone=0, oDiff=0, oBorrow=0. Shift registers, borrow register and counter are all 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - iStart=1 at an edge: load iA and iB into shift registers, clear the borrow register, clear the counter to 0, go to RUN.
  - iStart=0: stay in IDLE.
- RUN:
  - Each edge: d = a0 ^ b0 ^ bin; bout = (~a0 & b0) | (~(a0 ^ b0) & bin). Here a0/b0 are the shift-register LSBs and bin is the borrow register.
  - d shifts into the result register MSB-side; the result register shifts right. bout goes to the borrow register. Operand registers shift right. Counter increments.
  - On the edge where counter = N−1: go to DONE.
- DONE:
  - Registered outputs: oDone=1, oDiff = full result, oBorrow = final bout.
  - Next edge: go to IDLE unconditionally.
- Latency: oDone is high in the cycle after the N-th edge following the accepting edge, i.e. N+1 rising edges after iStart is sampled. With N=1: one RUN edge, then DONE.
- Result hold: oDiff and oBorrow hold their values after DONE until the next completion or reset. They do not change during a following RUN; they are updated only on entry to DONE.
- iStart in RUN or DONE: ignored; no queuing. iA/iB changes during RUN have no effect.
- iStart held high continuously: a new operation is accepted on the first edge in IDLE, i.e. back-to-back operations with one IDLE cycle between them.
- Reset mid-operation: iRst=1 overrides everything on that edge. Return to reset values; oDone is never asserted for the aborted operation.
- Width rules: all arithmetic is 1-bit per cell. oDiff wraps modulo 2^N. No signed interpretation inside the block.

Decomposition:
- Shared package (arith_pkg): state enum {IDLE, RUN, DONE}. No other shared constants needed.
- Sub-module full_subtractor: inputs iA, iB, iBorrow; outputs oDiff, oBorrow; purely combinational, one instance.
- The top level holds the FSM, counter, shift registers and borrow register.

Test Plan:
1. N=8, A=200, B=55, pulse iStart → after 9 edges oDone=1 for exactly one cycle, oDiff=145 (0x91), oBorrow=0.
2. A=55, B=200 → oDiff=0x6F, oBorrow=1; oBusy high for exactly 8 cycles, oReady low from the accepting edge until DONE exits.
3. Boundaries:
   - A=0, B=1 → oDiff=0xFF, oBorrow=1.
   - A=0x5A, B=0x5A → oDiff=0x00, oBorrow=0.
   - A=0xFF, B=0x00 → oDiff=0xFF, oBorrow=0.
4. Start A=10, B=3; pulse iStart again with A=1, B=2 on the 3rd RUN cycle, and change iA/iB mid-RUN → single oDone with oDiff=7, oBorrow=0; the second request is ignored.
5. Start A=100, B=1; assert iRst on the 4th RUN edge → next cycle all outputs at reset values, no oDone. Then start A=9, B=4 → oDiff=5, oBorrow=0.
6. N=1 build:
   - A=0, B=1 → oDone 2 edges after the accepting edge, oDiff=1, oBorrow=1.
   - iStart held high → consecutive oDone pulses separated by 2 cycles.
